// File: rtl/arm_mem_pkg.sv
// ============================================================================
// Module   : arm_mem_pkg
// Brief    : Shared types and defaults for the MEM-stage SRAM access controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_mem_pkg;

    localparam int DEF_BASE_ADDR   = 1024;
    localparam int DEF_WAIT_CYCLES = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Load/enable wait counter; 'last' flags the final cycle of a half.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int c_cnt_w = $clog2(WAIT_CYCLES) + 1;

    logic [c_cnt_w-1:0] r_count;

    assign last = (r_count == c_cnt_w'(WAIT_CYCLES - 1));

    // Wraps to zero on terminal count so the HI half starts fresh after LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= last ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_access_ctrl.sv
// ============================================================================
// Module   : sram_access_ctrl
// Brief    : Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses
//            and freezes the pipeline until done. SRAM_STAT_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_access_ctrl
    import arm_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [DATA_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_oe_dq,
    output logic               sram_we_n,
    output logic               sram_cs_n
`ifdef SRAM_STAT_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    mem_op_t           r_op;
    logic [DATA_W-1:0] r_off;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_req_off;
    logic [DATA_W-2:0] w_half_addr;
    logic              w_req;
    logic              w_last;
    logic              w_hi;
    logic              w_busy;
    logic              w_unused;

    assign w_req     = mem_r_en | mem_w_en;
    assign w_hi      = (r_state == HI);
    assign w_busy    = (r_state == LO) || (r_state == HI);
    assign freeze    = w_req & (r_state != DONE);
    assign w_req_off = addr - DATA_W'(BASE_ADDR);

    // Halfword address: word index with the half select appended; wraps silently.
    assign w_half_addr = {r_off[DATA_W-1:2], w_hi};
    assign w_unused    = ^{r_off[1:0], w_half_addr[DATA_W-2:SRAM_AW]};

    mem_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (r_state == IDLE),
        .en    (w_busy),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        ready      = 1'b0;
        sram_cs_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_oe_dq = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (r_state)
            IDLE: if (w_req) w_next = LO;
            LO, HI: begin
                if (w_last) w_next = w_hi ? DONE : HI;
                sram_cs_n = 1'b0;
                sram_addr = w_half_addr[SRAM_AW-1:0];
                if (r_op == OP_WR) begin
                    // Strobe released on the final cycle so addr/data are held past it.
                    sram_oe_dq = 1'b1;
                    sram_we_n  = w_last;
                    sram_wdata = w_hi ? r_wdata[DATA_W-1:SRAM_DW] : r_wdata[SRAM_DW-1:0];
                end
            end
            DONE: begin
                w_next = IDLE;
                ready  = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    // A simultaneous load and store is treated as a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_RD;
            r_off   <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_req) begin
            r_op    <= mem_r_en ? OP_RD : OP_WR;
            r_off   <= w_req_off;
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (r_op == OP_RD && w_busy && w_last) begin
            if (w_hi) begin
                rdata[DATA_W-1:SRAM_DW] <= sram_rdata;
            end else begin
                rdata[SRAM_DW-1:0] <= sram_rdata;
            end
        end
    end

`ifdef SRAM_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (ready) begin
            if (r_op == OP_RD && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (r_op == OP_WR && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
// ============================================================================
// Module   : tb_sram_access_ctrl
// Brief    : Self-checking bench for sram_access_ctrl with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_access_ctrl;

    localparam int W = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_r_en, mem_w_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_oe_dq, sram_we_n, sram_cs_n;
`ifdef SRAM_STAT_EN
    logic [15:0] rd_count, wr_count;
`endif

    sram_access_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_oe_dq (sram_oe_dq),
        .sram_we_n  (sram_we_n),
        .sram_cs_n  (sram_cs_n)
`ifdef SRAM_STAT_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: halfword array, write while strobe is low.
    bit [15:0] sram_mem [0:262143];
    assign sram_rdata = sram_cs_n ? 16'h0000 : sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_cs_n && !sram_we_n && sram_oe_dq) sram_mem[sram_addr] <= sram_wdata;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: 32-bit words keyed by word index, plus access counts.
    bit [31:0]   ref_words [int];
    logic [31:0] ref_last_rdata = 32'h0;
    int          ref_rd_n = 0;
    int          ref_wr_n = 0;

    function automatic int word_key(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) & 32'h1FFFF);
    endfunction

    task automatic model_access(input bit rd, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp);
        int k;
        k = word_key(a);
        if (rd) begin
            ref_last_rdata = ref_words.exists(k) ? ref_words[k] : 32'h0;
            ref_rd_n++;
        end else begin
            ref_words[k] = d;
            ref_wr_n++;
        end
        exp = ref_last_rdata;
    endtask

    // Called just after a rising edge with the DUT idle; returns likewise.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input int drop_at, output logic [31:0] got);
        int cyc, lat, frz, wel, oec, csc, aerr;
        bit done;
        logic [31:0] off;
        logic [17:0] base;
        off  = a - 32'd1024;
        base = 18'((off >> 2) * 2);
        mem_r_en = rd; mem_w_en = wr; addr = a; wdata = d;
        cyc = 0; lat = 0; frz = 0; wel = 0; oec = 0; csc = 0; aerr = 0; done = 0; got = '0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (freeze) frz++;
            if (!sram_we_n) wel++;
            if (sram_oe_dq) oec++;
            if (!sram_cs_n) begin
                if (sram_addr !== base + 18'(csc >= W)) aerr++;
                csc++;
            end
            if (ready) begin
                done = 1;
                lat  = cyc;
                got  = rdata;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == drop_at) begin
                mem_r_en = 1'b0;
                mem_w_en = 1'b0;
            end
        end
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        chk("ready_seen", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(2 * W + 1));
        chk("freeze_cycles", 32'(frz), 32'(drop_at != 0 ? drop_at : 2 * W + 1));
        chk("we_low_cycles", 32'(wel), rd ? 32'd0 : 32'(2 * (W - 1)));
        chk("oe_cycles", 32'(oec), rd ? 32'd0 : 32'(2 * W));
        chk("cs_cycles", 32'(csc), 32'(2 * W));
        chk("addr_seq_errs", 32'(aerr), 32'd0);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] got, exp;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h12345678};
        tbl[1]  = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h12345678};
        tbl[2]  = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF, 32'h12345678};
        tbl[4]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h00000000};
        tbl[5]  = '{1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'h00000000};
        tbl[6]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hCAFEF00D};
        tbl[7]  = '{1'b0, 1'b1, 32'd1025, 32'h0BADC0DE, 32'hCAFEF00D};
        tbl[8]  = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'h0BADC0DE};
        tbl[9]  = '{1'b0, 1'b1, 32'd0,    32'h11112222, 32'h0BADC0DE};
        tbl[10] = '{1'b1, 1'b0, 32'd0,    32'h0,        32'h11112222};
        tbl[11] = '{1'b1, 1'b0, 32'd1030, 32'h0,        32'hCAFEF00D};

        sram_mem[0] = 16'h5678;
        sram_mem[1] = 16'h1234;
        ref_words[0] = 32'h12345678;

        rst_n = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
        #2;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_cs_n", 32'(sram_cs_n), 32'd1);
        chk("rst_oe_dq", 32'(sram_oe_dq), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors run back to back: each request lands on the idle cycle after ready.
        for (int i = 0; i < 12; i++) begin
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 0, got);
            chk($sformatf("tbl%0d_rdata", i), got, tbl[i].exp);
            model_access(tbl[i].rd, tbl[i].a, tbl[i].d, exp);
            if (i == 3) chk("both_en_no_write", {sram_mem[1], sram_mem[0]}, 32'h12345678);
        end
        chk("wr_half4", 32'(sram_mem[4]), 32'h0000BEEF);
        chk("wr_half5", 32'(sram_mem[5]), 32'h0000DEAD);
        chk("wrap_half_lo", 32'(sram_mem[18'h3FE00]), 32'h00002222);
        chk("wrap_half_hi", 32'(sram_mem[18'h3FE01]), 32'h00001111);

        // Flush: store request dropped two cycles into LO must still complete.
        repeat (2) begin @(posedge clk); #1; end
        run_access(1'b0, 1'b1, 32'd1040, 32'h13579BDF, 3, got);
        model_access(1'b0, 32'd1040, 32'h13579BDF, exp);
        chk("flush_rdata_kept", got, exp);
        run_access(1'b1, 1'b0, 32'd1040, 32'h0, 0, got);
        model_access(1'b1, 32'd1040, 32'h0, exp);
        chk("flush_readback", got, 32'h13579BDF);

        for (int i = 0; i < 40; i++) begin
            int          kind, drop, gap;
            bit          rd, wr;
            logic [31:0] a, d;
            kind = $urandom_range(0, 3);
            rd   = (kind != 0);
            wr   = (kind == 0) || (kind == 3);
            a    = 32'd1024 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            d    = $urandom;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
            gap  = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            model_access(rd, a, d, exp);
            run_access(rd, wr, a, d, drop, got);
            chk($sformatf("rnd%0d_rdata", i), got, exp);
        end

`ifdef SRAM_STAT_EN
        chk("rd_count", 32'(rd_count), 32'(ref_rd_n));
        chk("wr_count", 32'(wr_count), 32'(ref_wr_n));
`endif

        // Asynchronous reset landing in the HI half of a write.
        @(posedge clk);
        #1;
        mem_w_en = 1'b1; addr = 32'd1024 + 32'd2000; wdata = 32'hA5A55A5A;
        repeat (2 * W - 3) @(posedge clk);
        #2;
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        chk("pre_rst_cs_n", 32'(sram_cs_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_rst_cs_n", 32'(sram_cs_n), 32'd1);
        chk("mid_rst_oe_dq", 32'(sram_oe_dq), 32'd0);
        chk("mid_rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_sram_wdata", 32'(sram_wdata), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
`ifdef SRAM_STAT_EN
        chk("mid_rst_rd_count", 32'(rd_count), 32'd0);
`endif
        mem_w_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
